// File: rtl/etapa_if.sv
// Instruction-fetch stage: owns the PC, runs the req/ack fetch to instruction memory, holds the IF/ID register.
// Latency: a word accepted with imem_ack appears on inst_ID the next cycle; 1-cycle memory sustains one fetch per cycle.
// Backpressure: stall freezes PC and IF/ID; a word acked while stalled is parked in a 1-entry buffer, no new request issued.
module etapa_if #(
    parameter logic [31:0] PC_INICIO = 32'h0000_0000,
    parameter logic [31:0] NOP       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MEM_RD_I,
    input  logic [1:0]  SEL_DIR,
    input  logic        resetIF,
    input  logic        stall,
    input  logic [31:0] dir_branch,
    input  logic [25:0] dir_jump,
    input  logic [31:0] dir_reg,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] inst_ID,
    output logic [31:0] pc4_ID,
    output logic        valid_ID,
    output logic [5:0]  opcode,
    output logic [5:0]  funct
);

    typedef enum logic [1:0] {
        INACTIVO = 2'd0,
        SOLICITA = 2'd1,
        RETENIDO = 2'd2
    } estado_t;

    estado_t     estado, estado_n;
    logic [31:0] pc, pc_n;
    logic [31:0] addr_n;
    logic [31:0] buffer, buffer_n;
    logic        descarte, descarte_n;
    logic [31:0] inst_n, pc4_n;
    logic        valid_n;
    logic        cargar;
    logic [31:0] dato_carga;
    logic        redirect;
    logic [31:0] destino;
    logic [31:0] pc_mas4;

    assign redirect = (SEL_DIR != 2'b00);
    assign pc_mas4  = pc + 32'd4;
    assign imem_req = (estado == SOLICITA);
    assign opcode   = inst_ID[31:26];
    assign funct    = inst_ID[5:0];

    // Redirect target; jump keeps the region bits of the instruction in ID.
    always_comb begin
        destino = pc;
        case (SEL_DIR)
            2'b01:   destino = dir_branch;
            2'b10:   destino = {pc4_ID[31:28], dir_jump, 2'b00};
            2'b11:   destino = dir_reg;
            default: destino = pc;
        endcase
    end

    // Fetch FSM: next state, next PC, request address, parked word and drop flag.
    always_comb begin
        estado_n   = estado;
        pc_n       = pc;
        addr_n     = imem_addr;
        buffer_n   = buffer;
        descarte_n = descarte;
        cargar     = 1'b0;
        dato_carga = imem_data;
        case (estado)
            INACTIVO: begin
                if (redirect) begin
                    pc_n = destino;
                end else if (MEM_RD_I && !stall) begin
                    estado_n = SOLICITA;
                    addr_n   = pc;
                end
            end
            SOLICITA: begin
                if (imem_ack) begin
                    if (redirect || resetIF || descarte) begin
                        // Word belongs to a squashed path or a flushed slot: drop it, PC stays
                        // (or takes the new target) so the right address is fetched next.
                        descarte_n = 1'b0;
                        if (redirect) begin
                            pc_n = destino;
                        end
                        estado_n = INACTIVO;
                    end else if (stall) begin
                        buffer_n = imem_data;
                        estado_n = RETENIDO;
                    end else begin
                        cargar = 1'b1;
                        pc_n   = pc_mas4;
                        if (MEM_RD_I) begin
                            addr_n = pc_mas4;
                        end else begin
                            estado_n = INACTIVO;
                        end
                    end
                end else if (redirect) begin
                    // The bus request cannot be withdrawn; let it finish and drop its data.
                    pc_n       = destino;
                    descarte_n = 1'b1;
                end
            end
            RETENIDO: begin
                if (redirect) begin
                    pc_n     = destino;
                    estado_n = INACTIVO;
                end else if (!stall) begin
                    if (resetIF) begin
                        estado_n = INACTIVO;
                    end else begin
                        cargar     = 1'b1;
                        dato_carga = buffer;
                        pc_n       = pc_mas4;
                        if (MEM_RD_I) begin
                            estado_n = SOLICITA;
                            addr_n   = pc_mas4;
                        end else begin
                            estado_n = INACTIVO;
                        end
                    end
                end
            end
            default: begin
                estado_n = INACTIVO;
            end
        endcase
    end

    // IF/ID next value: flush beats load, load beats hold, otherwise a bubble.
    always_comb begin
        inst_n  = inst_ID;
        pc4_n   = pc4_ID;
        valid_n = valid_ID;
        if (resetIF) begin
            inst_n  = NOP;
            valid_n = 1'b0;
        end else if (cargar) begin
            inst_n  = dato_carga;
            pc4_n   = pc_mas4;
            valid_n = 1'b1;
        end else if (!stall) begin
            inst_n  = NOP;
            valid_n = 1'b0;
        end
    end

    // State, PC, request address and IF/ID registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado    <= INACTIVO;
            pc        <= PC_INICIO;
            imem_addr <= 32'h0000_0000;
            buffer    <= NOP;
            descarte  <= 1'b0;
            inst_ID   <= NOP;
            pc4_ID    <= 32'h0000_0000;
            valid_ID  <= 1'b0;
        end else begin
            estado    <= estado_n;
            pc        <= pc_n;
            imem_addr <= addr_n;
            buffer    <= buffer_n;
            descarte  <= descarte_n;
            inst_ID   <= inst_n;
            pc4_ID    <= pc4_n;
            valid_ID  <= valid_n;
        end
    end

endmodule

// File: tb/tb_etapa_if.sv
module tb_etapa_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MEM_RD_I;
    logic [1:0]  SEL_DIR;
    logic        resetIF;
    logic        stall;
    logic [31:0] dir_branch;
    logic [25:0] dir_jump;
    logic [31:0] dir_reg;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] inst_ID;
    logic [31:0] pc4_ID;
    logic        valid_ID;
    logic [5:0]  opcode;
    logic [5:0]  funct;

    etapa_if dut (
        .clk(clk), .rst_n(rst_n), .MEM_RD_I(MEM_RD_I), .SEL_DIR(SEL_DIR),
        .resetIF(resetIF), .stall(stall), .dir_branch(dir_branch),
        .dir_jump(dir_jump), .dir_reg(dir_reg), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .inst_ID(inst_ID), .pc4_ID(pc4_ID), .valid_ID(valid_ID),
        .opcode(opcode), .funct(funct)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
        logic [5:0]  op;
        logic [5:0]  fn;
    } exp_t;

    exp_t        q_if[$];
    logic [31:0] q_req[$];
    int          checks = 0;
    int          errors = 0;
    int          lat = 1;
    bit          mem_manual = 1'b0;
    logic        man_ack = 1'b0;
    logic [31:0] man_data = 32'h0;
    bit          prev_valid = 1'b0;
    bit          prev_req = 1'b0;

    // Instruction memory contents.
    function automatic logic [31:0] word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0085_1020;
            32'h0000_0004: return 32'h0085_1022;
            32'h0000_0008: return 32'h28a4_000a;
            32'h0000_0020: return 32'h0085_1020;
            default:       return 32'h2000_0000 | a;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_if(input logic [31:0] i, input logic [31:0] p, input logic [5:0] o, input logic [5:0] f);
        exp_t e;
        e.inst = i; e.pc4 = p; e.op = o; e.fn = f;
        q_if.push_back(e);
    endtask

    // Memory model: acks in the lat-th cycle of each request.
    initial begin
        int cnt = 0;
        imem_ack  = 1'b0;
        imem_data = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_manual) begin
                imem_ack  = man_ack;
                imem_data = man_data;
                cnt       = 0;
            end else if (!imem_req) begin
                imem_ack = 1'b0;
                cnt      = 0;
            end else begin
                if (imem_ack) cnt = 0;
                if (cnt >= lat - 1) begin
                    imem_ack  = 1'b1;
                    imem_data = word(imem_addr);
                end else begin
                    imem_ack = 1'b0;
                    cnt++;
                end
            end
        end
    end

    // Monitor: pops the scoreboards on every IF/ID load and every new request.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_valid = 1'b0;
                prev_req   = 1'b0;
            end else begin
                if (valid_ID && !(stall && prev_valid)) begin
                    if (q_if.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_ifid: got %h expected none", inst_ID);
                    end else begin
                        exp_t e;
                        e = q_if.pop_front();
                        chk("inst_ID", inst_ID, e.inst);
                        chk("pc4_ID", pc4_ID, e.pc4);
                        chk("opcode", {26'h0, opcode}, {26'h0, e.op});
                        chk("funct", {26'h0, funct}, {26'h0, e.fn});
                    end
                end
                if (imem_req && (!prev_req || imem_ack)) begin
                    if (q_req.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_req: got %h expected none", imem_addr);
                    end else begin
                        chk("req_addr", imem_addr, q_req.pop_front());
                    end
                end
                prev_valid = valid_ID;
                prev_req   = imem_req;
            end
        end
    end

    task automatic do_reset(input int l);
        @(negedge clk);
        rst_n = 1'b0; MEM_RD_I = 1'b0; SEL_DIR = 2'b00; resetIF = 1'b0; stall = 1'b0;
        dir_branch = 32'h0; dir_jump = 26'h0; dir_reg = 32'h0;
        lat = l; mem_manual = 1'b0; man_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic branch_to(input logic [31:0] a);
        SEL_DIR = 2'b01; dir_branch = a;
        @(negedge clk);
        SEL_DIR = 2'b00;
    endtask

    task automatic wait_req(input logic [31:0] a);
        bit hit = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == a) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_req_timeout: got no request expected addr %h", a);
        end
    endtask

    task automatic wait_ack(input logic [31:0] a);
        bit hit = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (imem_req && imem_ack && imem_addr == a) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_ack_timeout: got no ack expected addr %h", a);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; MEM_RD_I = 1'b0; SEL_DIR = 2'b00; resetIF = 1'b0; stall = 1'b0;
        dir_branch = 32'h0; dir_jump = 26'h0; dir_reg = 32'h0;
        #12;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_inst", inst_ID, 32'h0);
        chk("rst_pc4", pc4_ID, 32'h0);
        chk("rst_valid", {31'h0, valid_ID}, 32'h0);

        // Back-to-back fetch with 1-cycle memory.
        do_reset(1);
        q_req.push_back(32'h0); q_req.push_back(32'h4); q_req.push_back(32'h8);
        push_if(32'h0085_1020, 32'h4, 6'h00, 6'h20);
        push_if(32'h0085_1022, 32'h8, 6'h00, 6'h22);
        push_if(32'h28a4_000a, 32'hC, 6'h0a, 6'h0a);
        MEM_RD_I = 1'b1;
        wait_req(32'h0);
        @(negedge clk);
        chk("b2b_addr4", imem_addr, 32'h4);
        chk("b2b_inst_add", inst_ID, 32'h0085_1020);
        @(negedge clk);
        chk("b2b_addr8", imem_addr, 32'h8);
        chk("b2b_valid", {31'h0, valid_ID}, 32'h1);
        MEM_RD_I = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_bubble", {31'h0, valid_ID}, 32'h0);

        // 3-cycle memory, stall at the slti ack.
        do_reset(3);
        q_req.push_back(32'h0); q_req.push_back(32'h4); q_req.push_back(32'h8);
        push_if(32'h0085_1020, 32'h4, 6'h00, 6'h20);
        push_if(32'h0085_1022, 32'h8, 6'h00, 6'h22);
        push_if(32'h28a4_000a, 32'hC, 6'h0a, 6'h0a);
        MEM_RD_I = 1'b1;
        wait_ack(32'h8);
        stall = 1'b1; MEM_RD_I = 1'b0;
        @(negedge clk);
        chk("stall_req0", {31'h0, imem_req}, 32'h0);
        chk("stall_hold_inst", inst_ID, 32'h0);
        chk("stall_hold_valid", {31'h0, valid_ID}, 32'h0);
        @(negedge clk);
        stall = 1'b0;
        chk("stall_req0_b", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        chk("stall_release_inst", inst_ID, 32'h28a4_000a);
        chk("stall_release_req", {31'h0, imem_req}, 32'h0);
        repeat (2) @(negedge clk);

        // Branch while a request to 0x10 is outstanding.
        do_reset(3);
        q_req.push_back(32'h0); q_req.push_back(32'h4); q_req.push_back(32'h8);
        q_req.push_back(32'hC); q_req.push_back(32'h10); q_req.push_back(32'h100);
        push_if(32'h0085_1020, 32'h4, 6'h00, 6'h20);
        push_if(32'h0085_1022, 32'h8, 6'h00, 6'h22);
        push_if(32'h28a4_000a, 32'hC, 6'h0a, 6'h0a);
        push_if(32'h2000_000C, 32'h10, 6'h08, 6'h0C);
        push_if(32'h2000_0100, 32'h104, 6'h08, 6'h00);
        MEM_RD_I = 1'b1;
        wait_req(32'h10);
        SEL_DIR = 2'b01; dir_branch = 32'h100;
        @(negedge clk);
        SEL_DIR = 2'b00;
        chk("br_old_addr_held", imem_addr, 32'h10);
        wait_req(32'h100);
        chk("br_valid_gap", {31'h0, valid_ID}, 32'h0);
        MEM_RD_I = 1'b0;
        repeat (4) @(negedge clk);

        // Jump: target built from pc4_ID region bits.
        do_reset(1);
        q_req.push_back(32'h0); q_req.push_back(32'h4); q_req.push_back(32'h100);
        push_if(32'h0085_1020, 32'h4, 6'h00, 6'h20);
        push_if(32'h0085_1022, 32'h8, 6'h00, 6'h22);
        push_if(32'h2000_0100, 32'h104, 6'h08, 6'h00);
        MEM_RD_I = 1'b1;
        wait_req(32'h4);
        MEM_RD_I = 1'b0;
        @(negedge clk);
        chk("jmp_pc4", pc4_ID, 32'h8);
        MEM_RD_I = 1'b1; SEL_DIR = 2'b10; dir_jump = 26'h0000040;
        @(negedge clk);
        SEL_DIR = 2'b00;
        chk("jmp_no_issue", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        chk("jmp_addr", imem_addr, 32'h100);
        chk("jmp_req", {31'h0, imem_req}, 32'h1);
        MEM_RD_I = 1'b0;
        repeat (2) @(negedge clk);

        // resetIF concurrent with the ack at 0x20.
        do_reset(1);
        q_req.push_back(32'h1C); q_req.push_back(32'h20); q_req.push_back(32'h20);
        push_if(32'h2000_001C, 32'h20, 6'h08, 6'h1C);
        push_if(32'h0085_1020, 32'h24, 6'h00, 6'h20);
        branch_to(32'h1C);
        MEM_RD_I = 1'b1;
        wait_req(32'h20);
        resetIF = 1'b1;
        @(negedge clk);
        resetIF = 1'b0;
        chk("flush_inst", inst_ID, 32'h0);
        chk("flush_valid", {31'h0, valid_ID}, 32'h0);
        chk("flush_req", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        chk("refetch_addr", imem_addr, 32'h20);
        chk("refetch_req", {31'h0, imem_req}, 32'h1);
        MEM_RD_I = 1'b0;
        @(negedge clk);
        chk("refetch_pc4", pc4_ID, 32'h24);

        // PC wrap at the top of the address space.
        do_reset(1);
        q_req.push_back(32'hFFFF_FFFC); q_req.push_back(32'h0);
        push_if(32'hFFFF_FFFC, 32'h0, 6'h3f, 6'h3c);
        push_if(32'h0085_1020, 32'h4, 6'h00, 6'h20);
        branch_to(32'hFFFF_FFFC);
        MEM_RD_I = 1'b1;
        wait_req(32'h0);
        MEM_RD_I = 1'b0;
        @(negedge clk);
        chk("wrap_pc4", pc4_ID, 32'h4);

        // Reset in the middle of a request, late ack afterwards.
        do_reset(1);
        mem_manual = 1'b1; man_ack = 1'b0;
        q_req.push_back(32'h40); q_req.push_back(32'h0);
        push_if(32'h0085_1020, 32'h4, 6'h00, 6'h20);
        branch_to(32'h40);
        MEM_RD_I = 1'b1;
        wait_req(32'h40);
        rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'h0, imem_req}, 32'h0);
        chk("midrst_addr", imem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; MEM_RD_I = 1'b0;
        man_ack = 1'b1; man_data = 32'hDEAD_BEEF;
        @(negedge clk);
        man_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("late_ack_valid", {31'h0, valid_ID}, 32'h0);
        chk("late_ack_req", {31'h0, imem_req}, 32'h0);
        mem_manual = 1'b0;
        MEM_RD_I = 1'b1;
        wait_req(32'h0);
        MEM_RD_I = 1'b0;
        @(negedge clk);
        chk("restart_inst", inst_ID, 32'h0085_1020);

        repeat (3) @(negedge clk);
        chk("if_queue_drained", q_if.size(), 32'h0);
        chk("req_queue_drained", q_req.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
